// File: rtl/apu_voice_bank_if.sv
// apu_voice_bank_if
//   Control/audio bundle between the voice bank and whatever drives it
//   (sequencer, CPU glue, VGA timing generator).
//   master : drives per-voice controls and the video timebase, reads sound/active
//   slave  : the voice bank itself
//   Signals:
//     trigger    [NUM_VOICES]          per-voice level trigger, rising edge starts a voice
//     noise_mode [NUM_VOICES]          1 = LFSR noise oscillator, 0 = square
//     fast_decay [NUM_VOICES]          1 = envelope -2/frame, 0 = -1/frame
//     pitch      [NUM_VOICES*PITCH_W]  per-voice half-period in scanlines, 0 = mute
//     frame_end                        one-cycle pulse per frame
//     pix_x      [10]                  current pixel column, 0 marks a new line
//     sound                            registered 1-bit mix
//     active     [NUM_VOICES]          voice currently sounding
interface apu_voice_bank_if #(
  parameter int unsigned NUM_VOICES = 3,
  parameter int unsigned PITCH_W    = 8
);
  logic [NUM_VOICES-1:0]         trigger;
  logic [NUM_VOICES-1:0]         noise_mode;
  logic [NUM_VOICES-1:0]         fast_decay;
  logic [NUM_VOICES*PITCH_W-1:0] pitch;
  logic                          frame_end;
  logic [9:0]                    pix_x;
  logic                          sound;
  logic [NUM_VOICES-1:0]         active;

  modport master (
    output trigger, noise_mode, fast_decay, pitch, frame_end, pix_x,
    input  sound, active
  );

  modport slave (
    input  trigger, noise_mode, fast_decay, pitch, frame_end, pix_x,
    output sound, active
  );
endinterface

// File: rtl/apu_voice_bank.sv
// apu_voice_bank
//   NUM_VOICES independent percussion/tone voices. Each voice starts on a
//   rising trigger edge, decays its envelope once per frame, runs a
//   scanline-rate oscillator (square or LFSR noise) and gates it with a
//   pixel-x PWM window sized by the envelope. Voices are OR-mixed into one
//   registered 1-bit output.
//   Ports:
//     clk    system/pixel clock
//     reset  synchronous, active-high; kills all voices, reloads the LFSR
//     bus    apu_voice_bank_if.slave (controls, timebase, sound, active)
module apu_voice_bank #(
  parameter int unsigned NUM_VOICES = 3,
  parameter int unsigned ENV_W      = 5,
  parameter int unsigned PITCH_W    = 8,
  parameter logic [12:0] LFSR_SEED  = 13'h0001
) (
  input  logic                clk,
  input  logic                reset,
  apu_voice_bank_if.slave     bus
);

  logic [12:0]           lfsr;
  logic                  lfsr_fb;
  logic                  line_tick;
  logic                  sound_q;
  logic [NUM_VOICES-1:0] trig_q;
  logic [NUM_VOICES-1:0] active_q;
  logic [NUM_VOICES-1:0] osc;
  logic [NUM_VOICES-1:0] start;
  logic [NUM_VOICES-1:0] v;
  logic [ENV_W-1:0]      env     [NUM_VOICES];
  logic [ENV_W-1:0]      step    [NUM_VOICES];
  logic [PITCH_W-1:0]    phase   [NUM_VOICES];
  logic [PITCH_W-1:0]    pitch_v [NUM_VOICES];

  always_comb begin
    line_tick = (bus.pix_x == '0);
    // Shift-left Fibonacci: a zero low part forces lfsr[12]=1, so fb=1 and
    // the register can never reach all-zero from a nonzero seed.
    lfsr_fb   = lfsr[12] ^ lfsr[8] ^ lfsr[2] ^ lfsr[0];
    start     = bus.trigger & ~trig_q;
    v         = '0;
    pitch_v   = '{default: '0};
    step      = '{default: '0};
    for (int unsigned i = 0; i < NUM_VOICES; i++) begin
      pitch_v[i] = bus.pitch[i*PITCH_W +: PITCH_W];
      step[i]    = bus.fast_decay[i] ? ENV_W'(2) : ENV_W'(1);
      // PWM window is env*4 pixels wide, compared at 10 bits.
      v[i]       = active_q[i] & osc[i] & (bus.pix_x < 10'({env[i], 2'b00}));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr     <= LFSR_SEED;
      trig_q   <= '0;
      active_q <= '0;
      osc      <= '0;
      sound_q  <= 1'b0;
      for (int unsigned i = 0; i < NUM_VOICES; i++) begin
        env[i]   <= '0;
        phase[i] <= '0;
      end
    end else begin
      lfsr    <= {lfsr[11:0], lfsr_fb};
      trig_q  <= bus.trigger;
      sound_q <= |v;
      for (int unsigned i = 0; i < NUM_VOICES; i++) begin
        if (start[i]) begin
          // A start edge overrides any frame tick in the same cycle.
          active_q[i] <= 1'b1;
          env[i]      <= '1;
          phase[i]    <= '0;
          osc[i]      <= 1'b0;
        end else begin
          if (bus.frame_end && active_q[i]) begin
            if (env[i] <= step[i]) begin
              env[i]      <= '0;
              active_q[i] <= 1'b0;
            end else begin
              env[i] <= env[i] - step[i];
            end
          end
          if (pitch_v[i] == '0) begin
            phase[i] <= '0;
            osc[i]   <= 1'b0;
          end else if (line_tick && active_q[i]) begin
            // >= rather than == so a mid-voice pitch drop below the current
            // phase wraps on the very next line instead of running to overflow.
            if (phase[i] >= pitch_v[i] - PITCH_W'(1)) begin
              phase[i] <= '0;
              osc[i]   <= bus.noise_mode[i] ? lfsr[0] : ~osc[i];
            end else begin
              phase[i] <= phase[i] + PITCH_W'(1);
            end
          end
        end
      end
    end
  end

  assign bus.sound  = sound_q;
  assign bus.active = active_q;

endmodule
